// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the ARM-subset calculator core.
// An instruction walks a FETCH/DECODE/execute FSM over 3-5 states (plus memory
// wait cycles). Only the state and the NZCV flag set are registered; all datapath
// enables and mux selects are Mealy outputs of state, instruction fields and flags.
module multicycle_control_unit #(
   parameter int ALU_CTRL_W = 2,
   parameter bit HANDSHAKE  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            cond,
   input  logic [1:0]            op,
   input  logic [5:0]            funct,
   input  logic [3:0]            rd,
   input  logic [3:0]            alu_flags,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  ir_write,
   output logic                  adr_src,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            result_src,
   output logic [1:0]            imm_src,
   output logic [1:0]            reg_src,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  pc_write,
   output logic                  reg_write,
   output logic                  mem_write,
   output logic [3:0]            flags,
   output logic [3:0]            state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
   localparam logic [ALU_CTRL_W-1:0] ALU_ORR = ALU_CTRL_W'(3);
   localparam logic [ALU_CTRL_W-1:0] ALU_EOR = (ALU_CTRL_W >= 3) ? ALU_CTRL_W'(4) : ALU_CTRL_W'(0);

   state_t                  state_reg, state_next;
   logic [3:0]              flags_reg, flags_next;
   logic                    cond_ex;
   logic                    accept;
   logic                    dp_ok, dp_cmp, dp_arith;
   logic [ALU_CTRL_W-1:0]   dp_ctrl;
   logic                    flag_n, flag_z, flag_c, flag_v;

   // Without the handshake every memory access is taken to finish in one cycle.
   assign accept = HANDSHAKE ? mem_ready : 1'b1;

   assign flag_n = flags_reg[3];
   assign flag_z = flags_reg[2];
   assign flag_c = flags_reg[1];
   assign flag_v = flags_reg[0];

   assign flags = flags_reg;
   assign state = state_reg;

   // Condition evaluation against the registered flags.
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Data-processing command decode; EOR and CMP exist only with a 3-bit ALU control.
   always_comb begin
      dp_ok    = 1'b1;
      dp_cmp   = 1'b0;
      dp_arith = 1'b0;
      dp_ctrl  = ALU_ADD;
      case (funct[4:1])
         4'b0100: dp_arith = 1'b1;
         4'b0010: begin dp_ctrl = ALU_SUB; dp_arith = 1'b1; end
         4'b0000: dp_ctrl = ALU_AND;
         4'b1100: dp_ctrl = ALU_ORR;
         4'b0001: begin
            if (ALU_CTRL_W >= 3) dp_ctrl = ALU_EOR;
            else                 dp_ok   = 1'b0;
         end
         4'b1010: begin
            if (ALU_CTRL_W >= 3) begin
               dp_ctrl  = ALU_SUB;
               dp_cmp   = 1'b1;
               dp_arith = 1'b1;
            end else begin
               dp_ok = 1'b0;
            end
         end
         default: dp_ok = 1'b0;
      endcase
   end

   // Flag update on the edge that leaves an execute state; C/V only for arithmetic.
   always_comb begin
      flags_next = flags_reg;
      if ((state_reg == EXECR || state_reg == EXECI) && dp_ok &&
          (funct[0] || dp_cmp) && cond_ex) begin
         flags_next[3:2] = alu_flags[3:2];
         if (dp_arith) flags_next[1:0] = alu_flags[1:0];
      end
   end

   // State and flag registers; reset abandons any instruction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= FETCH;
         flags_reg <= 4'b0000;
      end else begin
         state_reg <= state_next;
         flags_reg <= flags_next;
      end
   end

   // Next-state and Mealy output decode.
   always_comb begin
      state_next  = state_reg;
      mem_req     = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      imm_src     = 2'b00;
      reg_src     = 2'b00;
      alu_control = ALU_ADD;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      case (state_reg)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            // Gating with rst keeps every write enable low while reset is held.
            ir_write   = accept & ~rst;
            pc_write   = accept & ~rst;
            if (accept) state_next = DECODE;
         end
         DECODE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (op)
               2'b01:   state_next = MEMADR;
               2'b10:   state_next = BRANCH;
               2'b00:   state_next = funct[5] ? EXECI : EXECR;
               default: state_next = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_b  = 2'b01;
            imm_src    = 2'b01;
            state_next = funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (accept) state_next = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = cond_ex;
            state_next = FETCH;
         end
         MEMWR: begin
            mem_req    = 1'b1;
            adr_src    = 1'b1;
            reg_src[1] = 1'b1;
            mem_write  = cond_ex;
            if (accept) state_next = FETCH;
         end
         EXECR, EXECI: begin
            alu_src_b   = (state_reg == EXECI) ? 2'b01 : 2'b00;
            alu_control = dp_ctrl;
            state_next  = ALUWB;
         end
         ALUWB: begin
            if (dp_ok && !dp_cmp && cond_ex) begin
               reg_write = 1'b1;
               pc_write  = (rd == 4'd15);
            end
            state_next = FETCH;
         end
         BRANCH: begin
            imm_src    = 2'b10;
            reg_src[0] = 1'b1;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = cond_ex;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (3-bit ALU control with
// handshake, 2-bit ALU control without) each driven by an instruction-level
// model that queues the expected per-cycle outputs; a monitor pops and compares.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic [3:0] state;
      logic       mem_req;
      logic       ir_write;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] imm_src;
      logic [1:0] reg_src;
      logic [2:0] alu_control;
      logic       pc_write;
      logic       reg_write;
      logic       mem_write;
      logic [3:0] flags;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      rst_v;
   logic [1:0][3:0] cond_v, rd_v, alu_flags_v, flags_v, state_v;
   logic [1:0][1:0] op_v, alu_src_b_v, result_src_v, imm_src_v, reg_src_v;
   logic [1:0][5:0] funct_v;
   logic [1:0]      mem_ready_v, mem_req_v, ir_write_v, adr_src_v, alu_src_a_v;
   logic [1:0]      pc_write_v, reg_write_v, mem_write_v;
   logic [2:0]      alu_control0;
   logic [1:0]      alu_control1;

   logic [1:0][3:0] mflags;
   rec_t            q0[$];
   rec_t            q1[$];
   rec_t            act0, act1;
   int              n_cmp = 0;
   int              n_bad = 0;

   multicycle_control_unit #(.ALU_CTRL_W(3), .HANDSHAKE(1'b1)) dut0 (
      .clk(clk), .rst(rst_v[0]), .cond(cond_v[0]), .op(op_v[0]), .funct(funct_v[0]),
      .rd(rd_v[0]), .alu_flags(alu_flags_v[0]), .mem_ready(mem_ready_v[0]),
      .mem_req(mem_req_v[0]), .ir_write(ir_write_v[0]), .adr_src(adr_src_v[0]),
      .alu_src_a(alu_src_a_v[0]), .alu_src_b(alu_src_b_v[0]), .result_src(result_src_v[0]),
      .imm_src(imm_src_v[0]), .reg_src(reg_src_v[0]), .alu_control(alu_control0),
      .pc_write(pc_write_v[0]), .reg_write(reg_write_v[0]), .mem_write(mem_write_v[0]),
      .flags(flags_v[0]), .state(state_v[0]));

   multicycle_control_unit #(.ALU_CTRL_W(2), .HANDSHAKE(1'b0)) dut1 (
      .clk(clk), .rst(rst_v[1]), .cond(cond_v[1]), .op(op_v[1]), .funct(funct_v[1]),
      .rd(rd_v[1]), .alu_flags(alu_flags_v[1]), .mem_ready(mem_ready_v[1]),
      .mem_req(mem_req_v[1]), .ir_write(ir_write_v[1]), .adr_src(adr_src_v[1]),
      .alu_src_a(alu_src_a_v[1]), .alu_src_b(alu_src_b_v[1]), .result_src(result_src_v[1]),
      .imm_src(imm_src_v[1]), .reg_src(reg_src_v[1]), .alu_control(alu_control1),
      .pc_write(pc_write_v[1]), .reg_write(reg_write_v[1]), .mem_write(mem_write_v[1]),
      .flags(flags_v[1]), .state(state_v[1]));

   assign act0 = {state_v[0], mem_req_v[0], ir_write_v[0], adr_src_v[0], alu_src_a_v[0],
                  alu_src_b_v[0], result_src_v[0], imm_src_v[0], reg_src_v[0], alu_control0,
                  pc_write_v[0], reg_write_v[0], mem_write_v[0], flags_v[0]};
   assign act1 = {state_v[1], mem_req_v[1], ir_write_v[1], adr_src_v[1], alu_src_a_v[1],
                  alu_src_b_v[1], result_src_v[1], imm_src_v[1], reg_src_v[1], 1'b0, alu_control1,
                  pc_write_v[1], reg_write_v[1], mem_write_v[1], flags_v[1]};

   // Instance 0 waits on mem_ready and has EOR/CMP; instance 1 has neither.
   function automatic bit hs(input int u);
      return u == 0;
   endfunction

   function automatic logic [3:0] rnd4();
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic logic rnd_ready();
      return $urandom_range(0, 3) != 0;
   endfunction

   function automatic logic wait_mr(input int wn, input int k);
      if (wn < 0) return (k >= 20) ? 1'b1 : rnd_ready();
      return k >= wn;
   endfunction

   // ARM condition table over {N,Z,C,V}.
   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cf, v;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cf;
         4'h3: return !cf;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cf && !z;
         4'h9: return !cf || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic dp_model(input logic [3:0] cmd, input bit wide, output bit sup,
                           output logic [2:0] ctl, output bit cmp, output bit arith);
      sup = 1'b1; ctl = 3'd0; cmp = 1'b0; arith = 1'b0;
      case (cmd)
         4'b0100: begin ctl = 3'd0; arith = 1'b1; end
         4'b0010: begin ctl = 3'd1; arith = 1'b1; end
         4'b0000: ctl = 3'd2;
         4'b1100: ctl = 3'd3;
         4'b0001: if (wide) ctl = 3'd4; else sup = 1'b0;
         4'b1010: if (wide) begin ctl = 3'd1; cmp = 1'b1; arith = 1'b1; end else sup = 1'b0;
         default: sup = 1'b0;
      endcase
   endtask

   task automatic check_rec(input int u, input rec_t e, input rec_t a);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL cycle u%0d: state got %0d required %0d, outputs got %h required %h",
                  u, a.state, e.state, a, e);
      end
   endtask

   // Drive one cycle's inputs and queue the cycle's expected outputs.
   task automatic emit(input int u, input rec_t e_in, input logic mr, input logic [3:0] af,
                       input bit hold);
      rec_t e;
      e = e_in;
      e.flags = mflags[u];
      mem_ready_v[u] = mr;
      alu_flags_v[u] = af;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
      if (!hold) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One instruction from fetch to completion. wn<0 means random memory waits,
   // otherwise exactly wn not-ready cycles in the data-memory state.
   task automatic run_instr(input int u, input logic [3:0] c, input logic [1:0] o,
                            input logic [5:0] f, input logic [3:0] r, input int wn,
                            input logic [3:0] xaf, input bit use_af, input bit rst_mid);
      rec_t e;
      bit acc, sup, cmp, arith, ce;
      logic mr;
      logic [2:0] ctl;
      logic [3:0] af;
      int k;
      cond_v[u] = c; op_v[u] = o; funct_v[u] = f; rd_v[u] = r;
      $display("instr u%0d: cond=%h op=%b funct=%b rd=%0d flags=%b", u, c, o, f, r, mflags[u]);
      k = 0;
      do begin
         mr = (wn < 0 && k < 20) ? rnd_ready() : 1'b1;
         acc = !hs(u) || mr;
         e = '0; e.state = 4'd0; e.mem_req = 1'b1; e.alu_src_a = 1'b1;
         e.alu_src_b = 2'b10; e.result_src = 2'b10; e.ir_write = acc; e.pc_write = acc;
         emit(u, e, mr, rnd4(), 1'b0);
         k++;
      end while (!acc);
      e = '0; e.state = 4'd1; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      emit(u, e, rnd_ready(), rnd4(), 1'b0);
      case (o)
         2'b01: begin
            e = '0; e.state = 4'd2; e.alu_src_b = 2'b01; e.imm_src = 2'b01;
            emit(u, e, rnd_ready(), rnd4(), 1'b0);
            k = 0;
            do begin
               mr = wait_mr(wn, k);
               acc = !hs(u) || mr;
               e = '0; e.state = f[0] ? 4'd3 : 4'd5; e.mem_req = 1'b1; e.adr_src = 1'b1;
               if (!f[0]) begin
                  e.reg_src = 2'b10;
                  e.mem_write = cond_holds(c, mflags[u]);
               end
               emit(u, e, mr, rnd4(), rst_mid && f[0]);
               if (rst_mid && f[0]) begin
                  @(negedge clk);
                  #1 rst_v[u] = 1'b1;
                  #1;
                  n_cmp++;
                  if ({state_v[u], flags_v[u], reg_write_v[u], mem_write_v[u], pc_write_v[u],
                       ir_write_v[u]} !== 12'h000) begin
                     n_bad++;
                     $display("FAIL async reset u%0d: state=%0d flags=%b rw=%b mw=%b pcw=%b irw=%b required all zero",
                              u, state_v[u], flags_v[u], reg_write_v[u], mem_write_v[u],
                              pc_write_v[u], ir_write_v[u]);
                  end
                  mflags[u] = 4'b0000;
                  @(posedge clk);
                  #1 rst_v[u] = 1'b0;
                  return;
               end
               k++;
            end while (!acc);
            if (f[0]) begin
               e = '0; e.state = 4'd4; e.result_src = 2'b01;
               e.reg_write = cond_holds(c, mflags[u]);
               emit(u, e, rnd_ready(), rnd4(), 1'b0);
            end
         end
         2'b10: begin
            e = '0; e.state = 4'd9; e.imm_src = 2'b10; e.reg_src = 2'b01;
            e.alu_src_b = 2'b01; e.result_src = 2'b10;
            e.pc_write = cond_holds(c, mflags[u]);
            emit(u, e, rnd_ready(), rnd4(), 1'b0);
         end
         2'b00: begin
            dp_model(f[4:1], u == 0, sup, ctl, cmp, arith);
            af = use_af ? xaf : rnd4();
            ce = cond_holds(c, mflags[u]);
            e = '0; e.state = f[5] ? 4'd7 : 4'd6; e.alu_src_b = f[5] ? 2'b01 : 2'b00;
            e.alu_control = ctl;
            emit(u, e, rnd_ready(), af, 1'b0);
            if ((f[0] || cmp) && sup && ce) begin
               mflags[u][3:2] = af[3:2];
               if (arith) mflags[u][1:0] = af[1:0];
            end
            ce = cond_holds(c, mflags[u]);
            e = '0; e.state = 4'd8;
            e.reg_write = sup && !cmp && ce;
            e.pc_write  = sup && !cmp && ce && (r == 4'd15);
            emit(u, e, rnd_ready(), rnd4(), 1'b0);
         end
         default: ;
      endcase
   endtask

   task automatic run_random(input int u, input int n);
      for (int i = 0; i < n; i++) begin
         int sel;
         logic [1:0] o;
         logic [3:0] c, cmd, r;
         logic [5:0] f;
         sel = $urandom_range(0, 9);
         o = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
         c = ($urandom_range(0, 1) == 1) ? 4'hE : rnd4();
         case ($urandom_range(0, 6))
            0: cmd = 4'b0100;
            1: cmd = 4'b0010;
            2: cmd = 4'b0000;
            3: cmd = 4'b1100;
            4: cmd = 4'b0001;
            5: cmd = 4'b1010;
            default: cmd = rnd4();
         endcase
         f = (o == 2'b00) ? {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))}
                          : 6'($urandom_range(0, 63));
         r = ($urandom_range(0, 3) == 0) ? 4'd15 : rnd4();
         run_instr(u, c, o, f, r, -1, 4'h0, 1'b0, 1'b0);
      end
   endtask

   task automatic run_seq(input int u);
      run_instr(u, 4'hE, 2'b00, 6'b001000, 4'd1, 0, 4'h0, 1'b0, 1'b0);  // ADD R1,R2,R3
      run_instr(u, 4'hE, 2'b00, 6'b000101, 4'd2, 0, 4'b0100, 1'b1, 1'b0); // SUBS -> Z
      run_instr(u, 4'h0, 2'b10, 6'b000000, 4'd0, 0, 4'h0, 1'b0, 1'b0);  // BEQ taken
      run_instr(u, 4'h1, 2'b10, 6'b000000, 4'd0, 0, 4'h0, 1'b0, 1'b0);  // BNE not taken
      run_instr(u, 4'hE, 2'b01, 6'b011001, 4'd3, 2, 4'h0, 1'b0, 1'b0);  // LDR, 2 waits
      run_instr(u, 4'hF, 2'b01, 6'b011000, 4'd4, 1, 4'h0, 1'b0, 1'b0);  // STR never
      run_instr(u, 4'hE, 2'b00, 6'b010100, 4'd5, 0, 4'b0011, 1'b1, 1'b0); // CMP, S=0
      run_instr(u, 4'hE, 2'b00, 6'b011000, 4'd15, 0, 4'h0, 1'b0, 1'b0); // ORR to PC
      run_instr(u, 4'hE, 2'b00, 6'b100011, 4'd6, 0, 4'b1001, 1'b1, 1'b0); // EORS imm
      run_instr(u, 4'hE, 2'b11, 6'b000000, 4'd0, 0, 4'h0, 1'b0, 1'b0);  // op 11 no-op
      run_random(u, 80);
      run_instr(u, 4'hE, 2'b00, 6'b000101, 4'd7, 0, 4'b1010, 1'b1, 1'b0); // SUBS -> NC
      run_instr(u, 4'hE, 2'b01, 6'b011001, 4'd8, 3, 4'h0, 1'b0, 1'b1);  // LDR, reset in MEMRD
      run_random(u, 20);
   endtask

   initial begin
      rst_v = 2'b11;
      cond_v = '0; op_v = '0; funct_v = '0; rd_v = '0; alu_flags_v = '0;
      mem_ready_v = 2'b11;
      mflags = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         n_cmp++;
         if ({state_v[u], flags_v[u], mem_req_v[u], ir_write_v[u], pc_write_v[u],
              reg_write_v[u], mem_write_v[u]} !== 13'b0000_0000_10000) begin
            n_bad++;
            $display("FAIL reset u%0d: state=%0d flags=%b req=%b irw=%b pcw=%b rw=%b mw=%b required state 0 flags 0 req 1 enables 0",
                     u, state_v[u], flags_v[u], mem_req_v[u], ir_write_v[u], pc_write_v[u],
                     reg_write_v[u], mem_write_v[u]);
         end
      end
      @(posedge clk);
      #1 rst_v = 2'b00;
      fork
         forever begin
            @(negedge clk);
            if (q0.size() > 0) check_rec(0, q0.pop_front(), act0);
            if (q1.size() > 0) check_rec(1, q1.pop_front(), act1);
         end
      join_none
      fork
         run_seq(0);
         run_seq(1);
      join
      @(negedge clk);
      #1;
      n_cmp++;
      if (q0.size() + q1.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected cycles left unchecked, required 0", q0.size() + q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
